// File: rtl/result_dump_streamer_pkg.sv
// Shared definitions for the result dump streamer: FSM encoding, the UART byte
// width and helpers that size the word serializer.
package result_dump_streamer_pkg;

  // Width of one symbol handed to the UART transmitter.
  localparam int UART_BYTE_W = 8;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Number of UART bytes needed to carry one data-memory word.
  function automatic int calc_bytes(input int data_width);
    return (data_width + UART_BYTE_W - 1) / UART_BYTE_W;
  endfunction

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_dump_streamer_if.sv
// Bus bundle between the dump streamer, the data-memory read port and the
// UART transmitter.
//
// Handshake rules on the tx side: a byte moves when tx_valid && tx_ready are
// both high at a rising clk edge. Once tx_valid is raised, tx_valid and
// tx_data stay unchanged until that transfer happens (reset excepted).
// The memory side is a plain synchronous read: mem_rdata belongs to the
// mem_addr presented one cycle earlier with mem_rd_en high.
interface result_dump_streamer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
);
  import result_dump_streamer_pkg::*;

  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  // Streamer side: issues reads, produces bytes.
  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Environment side: memory and UART transmitter.
  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/result_dump_streamer_rising_edge_detect.sv
// Registered rising-edge detector. The previous-level flop resets to
// RESET_VAL, so with RESET_VAL=1 a level that is already high when reset
// releases is not reported as an edge.
module rising_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic level_d;

  // Next value of the delayed copy is simply the current level.
  always_comb begin
    level_d = level;
  end

  // Delayed copy of the level, reset to the configured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= RESET_VAL;
    end else begin
      level_q <= level_d;
    end
  end

  // High for the cycle in which the level is high but was low before.
  always_comb begin
    pulse = level & ~level_q;
  end

endmodule

// File: rtl/result_dump_streamer.sv
// Result dump streamer: after the processor signals completion, reads a
// fixed window of data-memory words and streams each one little-endian,
// byte by byte, toward the UART transmitter.
module result_dump_streamer
  import result_dump_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int START_ADDR = 0,
  parameter int WORD_COUNT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   processDone,
  result_dump_streamer_if.master bus,
  output logic                   dump_busy,
  output logic                   dump_done,
  output state_e                 state_dbg
);

  localparam int BYTES  = calc_bytes(DATA_WIDTH);
  localparam int BIDX_W = calc_idx_w(BYTES);
  localparam int WORD_W = BYTES * UART_BYTE_W;
  // One extra bit so a full 2**ADDR_WIDTH window can be counted.
  localparam int WIDX_W = ADDR_WIDTH + 1;

  localparam logic [WIDX_W-1:0]     LAST_WORD =
    WIDX_W'((WORD_COUNT > 0) ? (WORD_COUNT - 1) : 0);
  localparam logic [BIDX_W-1:0]     LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] START     = ADDR_WIDTH'(START_ADDR);
  localparam bit                    NO_WORDS  = (WORD_COUNT == 0);

  state_e              state_q,    state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_reg_q, word_reg_d;
  logic [WORD_W-1:0]   word_shifted;
  logic                trigger;

  // processDone rising edge; the delayed copy resets high so a level that
  // is already asserted out of reset does not start a dump.
  rising_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .level (processDone),
    .pulse (trigger)
  );

  // Sequencer: next state plus word/byte bookkeeping.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_reg_d = word_reg_q;

    unique case (state_q)
      ST_IDLE: begin
        // Edges seen in any other state are simply dropped.
        if (trigger) begin
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = NO_WORDS ? ST_FINISH : ST_READ;
        end
      end

      ST_READ: begin
        // The read strobe is issued in this state; data returns next cycle.
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Zero-extend so the padding bits of the top byte read as zero.
        word_reg_d = WORD_W'(bus.mem_rdata);
        byte_idx_d = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (bus.tx_ready) begin
          if (byte_idx_q != LAST_BYTE) begin
            // Next byte is presented straight away, no idle cycle.
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end else if (word_idx_q == LAST_WORD) begin
            state_d = ST_FINISH;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
            state_d    = ST_READ;
          end
        end
      end

      ST_FINISH: begin
        // Park the address back at the window start between dumps.
        word_idx_d = '0;
        byte_idx_d = '0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        word_idx_d = '0;
        byte_idx_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_reg_q <= word_reg_d;
    end
  end

  // Output decode: everything is a function of the registered state, so
  // tx_data/tx_valid cannot move while a byte waits for tx_ready.
  always_comb begin
    word_shifted  = word_reg_q >> {byte_idx_q, 3'b000};
    bus.mem_rd_en = (state_q == ST_READ);
    // Address wraps modulo 2**ADDR_WIDTH by truncation.
    bus.mem_addr  = START + word_idx_q[ADDR_WIDTH-1:0];
    bus.tx_valid  = (state_q == ST_SEND);
    bus.tx_data   = (state_q == ST_SEND) ? word_shifted[UART_BYTE_W-1:0]
                                         : '0;
    dump_busy     = (state_q == ST_READ) || (state_q == ST_CAPTURE) ||
                    (state_q == ST_SEND);
    dump_done     = (state_q == ST_FINISH);
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_result_dump_streamer.sv
// Bench for result_dump_streamer: three instances cover the default-style
// 12-bit dump, an empty window and a wrapping 4-bit address window.
module tb_result_dump_streamer;
  import result_dump_streamer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic pd_a = 1'b1, pd_b = 1'b0, pd_c = 1'b0;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  state_e st_a, st_b, st_c;

  result_dump_streamer_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) bus_a ();
  result_dump_streamer_if #(.DATA_WIDTH(12), .ADDR_WIDTH(12)) bus_b ();
  result_dump_streamer_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4))  bus_c ();

  result_dump_streamer #(.DATA_WIDTH(12), .ADDR_WIDTH(12), .START_ADDR(0), .WORD_COUNT(3)) dut_a (
    .clk(clk), .rst(rst), .processDone(pd_a), .bus(bus_a),
    .dump_busy(busy_a), .dump_done(done_a), .state_dbg(st_a));
  result_dump_streamer #(.DATA_WIDTH(12), .ADDR_WIDTH(12), .START_ADDR(0), .WORD_COUNT(0)) dut_b (
    .clk(clk), .rst(rst), .processDone(pd_b), .bus(bus_b),
    .dump_busy(busy_b), .dump_done(done_b), .state_dbg(st_b));
  result_dump_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_ADDR(14), .WORD_COUNT(4)) dut_c (
    .clk(clk), .rst(rst), .processDone(pd_c), .bus(bus_c),
    .dump_busy(busy_c), .dump_done(done_c), .state_dbg(st_c));

  // ---------------- memory models ----------------
  logic [11:0] mem_a [4096];
  logic [7:0]  mem_c [16];

  // Synchronous read; garbage when not reading exposes wrong capture timing.
  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    else                 bus_a.mem_rdata <= 12'($urandom);
    if (bus_c.mem_rd_en) bus_c.mem_rdata <= mem_c[bus_c.mem_addr];
    else                 bus_c.mem_rdata <= 8'($urandom);
  end

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_c[$];
  logic [3:0] exp_addr_c[$];
  int cyc_a = 0, bytes_a = 0, dones_a = 0, last_hs_a = -10, done_cyc_a = -10;
  int bad_b = 0, rds_c = 0, bytes_c = 0;
  logic stall_a = 1'b0;
  logic [7:0] stall_data_a = 8'h00;

  // Instance A monitor: byte order, hold-while-stalled, dump_done timing.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc_a++;
    if (stall_a) begin
      tests_run++;
      if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== stall_data_a) begin
        tests_failed++;
        $display("FAIL hold_a: valid=%b data=%h, required valid=1 data=%h", bus_a.tx_valid, bus_a.tx_data, stall_data_a);
      end
    end
    stall_a = bus_a.tx_valid && !bus_a.tx_ready && !rst;
    stall_data_a = bus_a.tx_data;
    if (bus_a.tx_valid && bus_a.tx_ready && !rst) begin
      tests_run++;
      bytes_a++;
      last_hs_a = cyc_a;
      if (exp_a.size() == 0) begin
        tests_failed++;
        $display("FAIL byte_a: got %h, required no byte", bus_a.tx_data);
      end else begin
        e = exp_a.pop_front();
        if (bus_a.tx_data !== e) begin
          tests_failed++;
          $display("FAIL byte_a: got %h, required %h", bus_a.tx_data, e);
        end
      end
    end
    if (done_a) begin
      dones_a++;
      done_cyc_a = cyc_a;
    end
  end

  // Instance B must never read, send or look busy.
  always @(negedge clk) begin
    if (bus_b.tx_valid || bus_b.mem_rd_en || busy_b) bad_b++;
  end

  // Instance C monitor: address sequence and byte contents.
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [7:0] eb;
    if (bus_c.mem_rd_en) begin
      tests_run++;
      rds_c++;
      if (exp_addr_c.size() == 0) begin
        tests_failed++;
        $display("FAIL addr_c: got %0d, required no read", bus_c.mem_addr);
      end else begin
        ea = exp_addr_c.pop_front();
        if (bus_c.mem_addr !== ea) begin
          tests_failed++;
          $display("FAIL addr_c: got %0d, required %0d", bus_c.mem_addr, ea);
        end
      end
    end
    if (bus_c.tx_valid && bus_c.tx_ready && !rst) begin
      tests_run++;
      bytes_c++;
      if (exp_c.size() == 0) begin
        tests_failed++;
        $display("FAIL byte_c: got %h, required no byte", bus_c.tx_data);
      end else begin
        eb = exp_c.pop_front();
        if (bus_c.tx_data !== eb) begin
          tests_failed++;
          $display("FAIL byte_c: got %h, required %h", bus_c.tx_data, eb);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: little-endian bytes of every word in the window.
  task automatic fill_exp_a();
    int unsigned word;
    exp_a.delete();
    for (int w = 0; w < 3; w++) begin
      word = 32'(mem_a[w % 4096]);
      for (int b = 0; b < 2; b++) exp_a.push_back(8'((word >> (8 * b)) & 32'hFF));
    end
  endtask

  task automatic load_fixed_a();
    mem_a[0] = 12'hABC;
    mem_a[1] = 12'h123;
    mem_a[2] = 12'h0F0;
  endtask

  task automatic clear_counts_a();
    bytes_a = 0;
    dones_a = 0;
    last_hs_a = -10;
    done_cyc_a = -10;
  endtask

  task automatic wait_done_a(input bit rand_ready, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) bus_a.tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    bus_a.tx_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit active;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if ({bus_a.mem_rd_en, bus_a.mem_addr, bus_a.tx_valid, bus_a.tx_data, busy_a, done_a} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b addr=%h v=%b d=%h busy=%b done=%b, required all zero", bus_a.mem_rd_en, bus_a.mem_addr, bus_a.tx_valid, bus_a.tx_data, busy_a, done_a);
    end
    tests_run++;
    if (st_a !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", st_a, ST_IDLE);
    end
    tests_run++;
    if (bus_c.mem_addr !== 4'd14) begin
      tests_failed++;
      $display("FAIL reset_addr_c: got %0d, required 14", bus_c.mem_addr);
    end
    tick();
    rst = 1'b0;
    active = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a || bus_a.tx_valid || bus_a.mem_rd_en) active = 1'b1;
    end
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL high_at_reset_release: dump activity=%b, required 0", active);
    end
  endtask

  task automatic test_basic();
    int first_k;
    bit seen;
    load_fixed_a();
    fill_exp_a();
    clear_counts_a();
    pd_a = 1'b0;
    tick();
    tick();
    pd_a = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        tests_run++;
        if ({bus_a.mem_rd_en, bus_a.mem_addr, busy_a} !== {1'b1, 12'd0, 1'b1}) begin
          tests_failed++;
          $display("FAIL read_cycle: rd=%b addr=%0d busy=%b, required rd=1 addr=0 busy=1", bus_a.mem_rd_en, bus_a.mem_addr, busy_a);
        end
      end
      if (bus_a.tx_valid && first_k == 0) first_k = k;
    end
    tests_run++;
    if (first_k != 3) begin
      tests_failed++;
      $display("FAIL first_valid_latency: got %0d cycles, required 3", first_k);
    end
    wait_done_a(1'b0, seen);
    repeat (3) tick();
    tests_run++;
    if (!seen || bytes_a != 6 || exp_a.size() != 0 || dones_a != 1) begin
      tests_failed++;
      $display("FAIL basic_dump: done_seen=%b bytes=%0d left=%0d dones=%0d, required 1 6 0 1", seen, bytes_a, exp_a.size(), dones_a);
    end
    tests_run++;
    if (done_cyc_a != last_hs_a + 1) begin
      tests_failed++;
      $display("FAIL done_timing: done at %0d, required %0d", done_cyc_a, last_hs_a + 1);
    end
  endtask

  task automatic test_random_ready();
    bit seen;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) load_fixed_a();
      else for (int w = 0; w < 3; w++) mem_a[w] = 12'($urandom);
      fill_exp_a();
      clear_counts_a();
      pd_a = 1'b0;
      tick();
      pd_a = 1'b1;
      wait_done_a(1'b1, seen);
      repeat (2) tick();
      tests_run++;
      if (!seen || bytes_a != 6 || exp_a.size() != 0 || dones_a != 1) begin
        tests_failed++;
        $display("FAIL random_ready_%0d: done_seen=%b bytes=%0d left=%0d dones=%0d, required 1 6 0 1", it, seen, bytes_a, exp_a.size(), dones_a);
      end
    end
  endtask

  task automatic test_retrigger();
    bit seen;
    bit active;
    load_fixed_a();
    fill_exp_a();
    clear_counts_a();
    pd_a = 1'b0;
    tick();
    pd_a = 1'b1;
    repeat (4) tick();
    pd_a = 1'b0;
    tick();
    pd_a = 1'b1;
    wait_done_a(1'b0, seen);
    active = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy_a || bus_a.tx_valid) active = 1'b1;
    end
    tests_run++;
    if (!seen || active || bytes_a != 6 || dones_a != 1) begin
      tests_failed++;
      $display("FAIL retrigger_ignored: done_seen=%b rerun=%b bytes=%0d dones=%0d, required 1 0 6 1", seen, active, bytes_a, dones_a);
    end
    pd_a = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int hs;
    bit seen;
    load_fixed_a();
    fill_exp_a();
    clear_counts_a();
    bus_a.tx_ready = 1'b1;
    pd_a = 1'b0;
    tick();
    pd_a = 1'b1;
    hs = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      @(negedge clk);
      if (bus_a.tx_valid && bus_a.tx_ready) hs++;
    end
    tick();
    bus_a.tx_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_a.tx_valid, bus_a.tx_data} !== {1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL pending_byte: v=%b d=%h, required v=1 d=01", bus_a.tx_valid, bus_a.tx_data);
    end
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_a.mem_rd_en, bus_a.mem_addr, bus_a.tx_valid, bus_a.tx_data, busy_a, done_a} !== 24'h0 || st_a !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset: rd=%b addr=%h v=%b d=%h busy=%b done=%b st=%0d, required all zero and IDLE", bus_a.mem_rd_en, bus_a.mem_addr, bus_a.tx_valid, bus_a.tx_data, busy_a, done_a, st_a);
    end
    tick();
    rst = 1'b0;
    bus_a.tx_ready = 1'b1;
    fill_exp_a();
    clear_counts_a();
    pd_a = 1'b0;
    tick();
    pd_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_a.mem_rd_en, bus_a.mem_addr} !== {1'b1, 12'd0}) begin
      tests_failed++;
      $display("FAIL restart_addr: rd=%b addr=%0d, required rd=1 addr=0", bus_a.mem_rd_en, bus_a.mem_addr);
    end
    wait_done_a(1'b0, seen);
    repeat (2) tick();
    tests_run++;
    if (!seen || bytes_a != 6 || exp_a.size() != 0) begin
      tests_failed++;
      $display("FAIL restart_dump: done_seen=%b bytes=%0d left=%0d, required 1 6 0", seen, bytes_a, exp_a.size());
    end
  endtask

  task automatic test_zero_words();
    bus_b.tx_ready = 1'b1;
    bad_b = 0;
    pd_b = 1'b0;
    tick();
    pd_b = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_early: done=%b at trigger cycle, required 0", done_b);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({done_b, busy_b} !== 2'b10) begin
      tests_failed++;
      $display("FAIL zero_done_t1: done=%b busy=%b, required done=1 busy=0", done_b, busy_b);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (done_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_once: done=%b, required 0", done_b);
    end
    repeat (5) tick();
    tests_run++;
    if (bad_b != 0) begin
      tests_failed++;
      $display("FAIL zero_no_activity: active cycles=%0d, required 0", bad_b);
    end
  endtask

  task automatic test_addr_wrap();
    bit seen;
    int a;
    bus_c.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem_c[i] = 8'($urandom);
    exp_c.delete();
    exp_addr_c.delete();
    for (int w = 0; w < 4; w++) begin
      a = (14 + w) % 16;
      exp_addr_c.push_back(4'(a));
      exp_c.push_back(mem_c[a]);
    end
    rds_c = 0;
    bytes_c = 0;
    pd_c = 1'b0;
    tick();
    pd_c = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_c) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) tick();
    tests_run++;
    if (!seen || rds_c != 4 || bytes_c != 4 || exp_c.size() != 0 || exp_addr_c.size() != 0) begin
      tests_failed++;
      $display("FAIL addr_wrap: done_seen=%b reads=%0d bytes=%0d, required 1 4 4", seen, rds_c, bytes_c);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.tx_ready = 1'b1;
    bus_b.tx_ready = 1'b1;
    bus_c.tx_ready = 1'b1;
    bus_b.mem_rdata = '0;
    load_fixed_a();
    test_reset();
    test_basic();
    test_random_ready();
    test_retrigger();
    test_reset_mid();
    test_zero_words();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
